// File: rtl/game_round_ctrl.sv
// ---------------------------------------------------------------------------
// game_round_ctrl
//   Round sequencer for the LED-grid game. It picks a random target cell and
//   colour from the LCG and arms a tick-based timeout. Player presses are
//   resolved as a hit or a miss. Score and lives are kept here, and the block
//   runs the start and game-over phases.
//
// Ports
//   i_clk           system clock
//   i_rst           synchronous reset, active-high
//   i_tick          one-cycle game-tick enable pulse
//   i_start         start/restart request (level)
//   i_rand[31:0]    LCG output; [5:0] gives the cell, [31:30] gives the colour
//   i_press_valid   one-cycle pulse: the player pressed a cell
//   i_press_pos     cell index of the press
//   o_target_pos    current target cell (held outside WAIT)
//   o_target_color  0=red 1=green 2=blue 3=white (held outside WAIT)
//   o_target_valid  target is armed (WAIT)
//   o_flash_hit     hit flash (HIT)
//   o_flash_miss    miss flash (MISS)
//   o_score         hits this game, saturating
//   o_lives         lives remaining
//   o_game_over     game over (OVER)
// ---------------------------------------------------------------------------
module game_round_ctrl #(
  parameter int TIMEOUT_TICKS = 4,
  parameter int FLASH_TICKS   = 2,
  parameter int LIVES         = 3,
  parameter int SCORE_W       = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic [31:0]        i_rand,
  input  logic               i_press_valid,
  input  logic [5:0]         i_press_pos,
  output logic [5:0]         o_target_pos,
  output logic [1:0]         o_target_color,
  output logic               o_target_valid,
  output logic               o_flash_hit,
  output logic               o_flash_miss,
  output logic [SCORE_W-1:0] o_score,
  output logic [1:0]         o_lives,
  output logic               o_game_over
);

  localparam int CNT_MAX = (TIMEOUT_TICKS > FLASH_TICKS) ? TIMEOUT_TICKS : FLASH_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The counter value whose next tick completes the interval.
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0]   FLASH_LAST   = CNT_W'(FLASH_TICKS - 1);
  localparam logic [1:0]         LIVES_INIT   = 2'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_WAIT  = 3'd2,
    S_HIT   = 3'd3,
    S_MISS  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [5:0]         prev_pos, prev_next;
  logic [5:0]         pos_next;
  logic [1:0]         color_next;
  logic [SCORE_W-1:0] score_next;
  logic [1:0]         lives_next;

  // Only the cell and colour fields of the LCG word are consumed.
  logic unused_rand;
  assign unused_rand = ^i_rand[29:6];

  // Never present the same cell twice in a row; bump by one (mod 64) on a repeat.
  logic [5:0] rand_pos, spawn_pos;
  assign rand_pos  = i_rand[5:0];
  assign spawn_pos = (rand_pos == prev_pos) ? rand_pos + 6'd1 : rand_pos;

  logic [1:0] lives_dec;
  assign lives_dec = (o_lives != 2'd0) ? o_lives - 2'd1 : 2'd0;

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    prev_next  = prev_pos;
    pos_next   = o_target_pos;
    color_next = o_target_color;
    score_next = o_score;
    lives_next = o_lives;

    case (state)
      S_IDLE, S_OVER: begin
        if (i_start) begin
          score_next = '0;
          lives_next = LIVES_INIT;
          cnt_next   = '0;
          state_next = S_SPAWN;
        end
      end

      S_SPAWN: begin
        pos_next   = spawn_pos;
        color_next = i_rand[31:30];
        prev_next  = spawn_pos;
        cnt_next   = '0;
        state_next = S_WAIT;
      end

      S_WAIT: begin
        // A press always beats a timeout tick in the same cycle.
        if (i_press_valid && (i_press_pos == o_target_pos)) begin
          if (o_score != SCORE_MAX) score_next = o_score + SCORE_W'(1);
          cnt_next   = '0;
          state_next = S_HIT;
        end else if (i_press_valid) begin
          lives_next = lives_dec;
          cnt_next   = '0;
          state_next = S_MISS;
        end else if (i_tick) begin
          if (cnt == TIMEOUT_LAST) begin
            lives_next = lives_dec;
            cnt_next   = '0;
            state_next = S_MISS;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end

      S_HIT: begin
        if (i_tick) begin
          if (cnt == FLASH_LAST) begin
            cnt_next   = '0;
            state_next = S_SPAWN;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end

      S_MISS: begin
        // Lives were already decremented on entry, so o_lives is current here.
        if (i_tick) begin
          if (cnt == FLASH_LAST) begin
            cnt_next   = '0;
            state_next = (o_lives == 2'd0) ? S_OVER : S_SPAWN;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
    if (i_rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      prev_pos       <= '0;
      o_target_pos   <= '0;
      o_target_color <= '0;
      o_score        <= '0;
      o_lives        <= LIVES_INIT;
      o_target_valid <= 1'b0;
      o_flash_hit    <= 1'b0;
      o_flash_miss   <= 1'b0;
      o_game_over    <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      prev_pos       <= prev_next;
      o_target_pos   <= pos_next;
      o_target_color <= color_next;
      o_score        <= score_next;
      o_lives        <= lives_next;
      // Status flags are decoded from the next state so they change together with the state register.
      o_target_valid <= (state_next == S_WAIT);
      o_flash_hit    <= (state_next == S_HIT);
      o_flash_miss   <= (state_next == S_MISS);
      o_game_over    <= (state_next == S_OVER);
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_round_ctrl
//   Self-checking bench for game_round_ctrl. The main table holds cycle-by-cycle
//   stimulus with the expected registered outputs after each edge. The longer
//   corner cases are built in loops: score saturation and reset in mid-round.
//   Each applied vector pushes its expectation into a queue. The queue is
//   popped and compared one time unit after the edge.
// ---------------------------------------------------------------------------
module tb_game_round_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [31:0] rnd = '0;
  logic        press_valid = 1'b0;
  logic [5:0]  press_pos = '0;
  logic [5:0]  target_pos;
  logic [1:0]  target_color;
  logic        target_valid;
  logic        flash_hit;
  logic        flash_miss;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        game_over;

  always #5 clk = ~clk;

  game_round_ctrl #(
    .TIMEOUT_TICKS(4),
    .FLASH_TICKS  (2),
    .LIVES        (3),
    .SCORE_W      (8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_tick         (tick),
    .i_start        (start),
    .i_rand         (rnd),
    .i_press_valid  (press_valid),
    .i_press_pos    (press_pos),
    .o_target_pos   (target_pos),
    .o_target_color (target_color),
    .o_target_valid (target_valid),
    .o_flash_hit    (flash_hit),
    .o_flash_miss   (flash_miss),
    .o_score        (score),
    .o_lives        (lives),
    .o_game_over    (game_over)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic        tick;
    logic        pv;
    logic [5:0]  pp;
    logic [31:0] rnd;
    logic [21:0] exp;   // {pos, color, valid, hit, miss, over, score, lives}
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string name, logic r, logic st, logic tk, logic pv,
                              logic [5:0] pp, logic [31:0] rd,
                              logic [5:0] pos, logic [1:0] col, logic v, logic h,
                              logic m, logic o, logic [7:0] sc, logic [1:0] lv);
    vec_t x;
    x.name  = name;
    x.rst   = r;
    x.start = st;
    x.tick  = tk;
    x.pv    = pv;
    x.pp    = pp;
    x.rnd   = rd;
    x.exp   = {pos, col, v, h, m, o, sc, lv};
    return x;
  endfunction

  task automatic check(input vec_t e);
    logic [21:0] act;
    act = {target_pos, target_color, target_valid, flash_hit, flash_miss,
           game_over, score, lives};
    n_vec++;
    if (act !== e.exp) begin
      n_bad++;
      $display("FAIL %s: got pos=%0d col=%0d v%b h%b m%b o%b score=%0d lives=%0d, want pos=%0d col=%0d v%b h%b m%b o%b score=%0d lives=%0d",
               e.name, act[21:16], act[15:14], act[13], act[12], act[11], act[10],
               act[9:2], act[1:0], e.exp[21:16], e.exp[15:14], e.exp[13], e.exp[12],
               e.exp[11], e.exp[10], e.exp[9:2], e.exp[1:0]);
    end
  endtask

  task automatic apply(input vec_t v);
    rst         = v.rst;
    start       = v.start;
    tick        = v.tick;
    press_valid = v.pv;
    press_pos   = v.pp;
    rnd         = v.rnd;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check(exp_q.pop_front());
  endtask

  initial begin
    //            name          rst st tk pv pp  rand           pos col v h m o score lives
    tbl.push_back(mk("reset0",      1, 0, 0, 0, 0,  32'h0,         0, 0, 0,0,0,0, 0, 3));
    tbl.push_back(mk("reset1",      1, 1, 1, 1, 3,  32'h0,         0, 0, 0,0,0,0, 0, 3));
    tbl.push_back(mk("idle_hold",   0, 0, 1, 1, 0,  32'h0,         0, 0, 0,0,0,0, 0, 3));
    tbl.push_back(mk("start",       0, 1, 0, 0, 0,  32'hC000_0015, 0, 0, 0,0,0,0, 0, 3));
    tbl.push_back(mk("spawn21",     0, 0, 0, 0, 0,  32'hC000_0015, 21,3, 1,0,0,0, 0, 3));
    tbl.push_back(mk("hit21",       0, 0, 0, 1, 21, 32'h0,         21,3, 0,1,0,0, 1, 3));
    tbl.push_back(mk("hit_t1",      0, 0, 1, 0, 0,  32'h0,         21,3, 0,1,0,0, 1, 3));
    tbl.push_back(mk("hit_t2",      0, 0, 1, 0, 0,  32'h0,         21,3, 0,0,0,0, 1, 3));
    tbl.push_back(mk("spawn_rep",   0, 0, 0, 0, 0,  32'h4000_0015, 22,1, 1,0,0,0, 1, 3));
    tbl.push_back(mk("to_t1",       0, 0, 1, 0, 0,  32'h0,         22,1, 1,0,0,0, 1, 3));
    tbl.push_back(mk("to_idle",     0, 0, 0, 0, 0,  32'h0,         22,1, 1,0,0,0, 1, 3));
    tbl.push_back(mk("to_t2",       0, 0, 1, 0, 0,  32'h0,         22,1, 1,0,0,0, 1, 3));
    tbl.push_back(mk("to_t3",       0, 0, 1, 0, 0,  32'h0,         22,1, 1,0,0,0, 1, 3));
    tbl.push_back(mk("to_t4_miss",  0, 0, 1, 0, 0,  32'h0,         22,1, 0,0,1,0, 1, 2));
    tbl.push_back(mk("miss_press",  0, 0, 0, 1, 22, 32'h0,         22,1, 0,0,1,0, 1, 2));
    tbl.push_back(mk("miss_t1",     0, 0, 1, 0, 0,  32'h0,         22,1, 0,0,1,0, 1, 2));
    tbl.push_back(mk("miss_t2",     0, 0, 1, 0, 0,  32'h0,         22,1, 0,0,0,0, 1, 2));
    tbl.push_back(mk("spawn_st",    0, 1, 0, 0, 0,  32'h8000_0015, 21,2, 1,0,0,0, 1, 2));
    tbl.push_back(mk("race_t1",     0, 0, 1, 0, 0,  32'h0,         21,2, 1,0,0,0, 1, 2));
    tbl.push_back(mk("race_t2",     0, 0, 1, 0, 0,  32'h0,         21,2, 1,0,0,0, 1, 2));
    tbl.push_back(mk("race_t3",     0, 0, 1, 0, 0,  32'h0,         21,2, 1,0,0,0, 1, 2));
    tbl.push_back(mk("race_hit",    0, 0, 1, 1, 21, 32'h0,         21,2, 0,1,0,0, 2, 2));
    tbl.push_back(mk("race_ht1",    0, 0, 1, 0, 0,  32'h0,         21,2, 0,1,0,0, 2, 2));
    tbl.push_back(mk("race_ht2",    0, 0, 1, 0, 0,  32'h0,         21,2, 0,0,0,0, 2, 2));
    tbl.push_back(mk("spawn63",     0, 0, 0, 0, 0,  32'h0000_003F, 63,0, 1,0,0,0, 2, 2));
    tbl.push_back(mk("wrong1",      0, 0, 0, 1, 5,  32'h0,         63,0, 0,0,1,0, 2, 1));
    tbl.push_back(mk("wrong1_t1",   0, 0, 1, 0, 0,  32'h0,         63,0, 0,0,1,0, 2, 1));
    tbl.push_back(mk("wrong1_t2",   0, 0, 1, 0, 0,  32'h0,         63,0, 0,0,0,0, 2, 1));
    tbl.push_back(mk("spawn_wrap",  0, 0, 0, 0, 0,  32'h0000_003F, 0, 0, 1,0,0,0, 2, 1));
    tbl.push_back(mk("wrong2",      0, 0, 1, 1, 5,  32'h0,         0, 0, 0,0,1,0, 2, 0));
    tbl.push_back(mk("wrong2_t1",   0, 0, 1, 0, 0,  32'h0,         0, 0, 0,0,1,0, 2, 0));
    tbl.push_back(mk("over",        0, 0, 1, 0, 0,  32'h0,         0, 0, 0,0,0,1, 2, 0));
    tbl.push_back(mk("over_hold",   0, 0, 1, 1, 0,  32'h0,         0, 0, 0,0,0,1, 2, 0));
    tbl.push_back(mk("restart",     0, 1, 0, 0, 0,  32'h0,         0, 0, 0,0,0,0, 0, 3));
    tbl.push_back(mk("spawn_rs",    0, 0, 0, 0, 0,  32'hC000_0015, 21,3, 1,0,0,0, 0, 3));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Score saturation: 256 hits from score 0; the 256th must leave it at 255.
    begin
      logic [5:0] cur_pos;
      logic [1:0] cur_col;
      logic [5:0] nxt;
      logic [7:0] sc;
      cur_pos = 6'd21;
      cur_col = 2'd3;
      for (int k = 1; k <= 256; k++) begin
        sc  = (k > 255) ? 8'd255 : 8'(k);
        nxt = (k % 2 == 1) ? 6'd10 : 6'd11;
        apply(mk($sformatf("sat_hit%0d", k), 0, 0, 0, 1, cur_pos, 32'h0,
                 cur_pos, cur_col, 0, 1, 0, 0, sc, 3));
        apply(mk($sformatf("sat_t1_%0d", k), 0, 0, 1, 0, 0, 32'h0,
                 cur_pos, cur_col, 0, 1, 0, 0, sc, 3));
        apply(mk($sformatf("sat_t2_%0d", k), 0, 0, 1, 0, 0, 32'h0,
                 cur_pos, cur_col, 0, 0, 0, 0, sc, 3));
        apply(mk($sformatf("sat_spawn%0d", k), 0, 0, 0, 0, 0, {2'b01, 24'h0, nxt},
                 nxt, 2'd1, 1, 0, 0, 0, sc, 3));
        cur_pos = nxt;
        cur_col = 2'd1;
      end
    end

    // Reset in mid-round (WAIT): every output returns to its reset value.
    // prev_pos is also cleared, so a following rand of 0 is bumped to cell 1.
    apply(mk("rst_wait",   1, 1, 1, 1, 11, 32'h0,         0, 0, 0,0,0,0, 0, 3));
    apply(mk("rst_idle",   0, 0, 1, 0, 0,  32'h0,         0, 0, 0,0,0,0, 0, 3));
    apply(mk("rst_start",  0, 1, 0, 0, 0,  32'h0,         0, 0, 0,0,0,0, 0, 3));
    apply(mk("rst_spawn",  0, 0, 0, 0, 0,  32'h4000_0000, 1, 1, 1,0,0,0, 0, 3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
